// File: rtl/circuit_test_pkg.sv
// circuit_test_pkg
// Shared definitions for the circuit test sequencer: the sequencer state
// encoding, the stimulus table applied to the circuit under test, and the
// lower limits for the settle and sample windows.
// Stimulus entries are {clock_role, data_role}, listed from entry 15 down
// to entry 0, so the run applies entry 0 first.
package circuit_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SETTLE,
        ST_SAMPLE,
        ST_COMPARE,
        ST_DONE
    } state_t;

    localparam int MIN_SETTLE_CYCLES = 2;
    localparam int MIN_SAMPLES       = 1;

    localparam logic [15:0][1:0] STIM_TABLE = {
        2'b10, 2'b01, 2'b11, 2'b01,
        2'b00, 2'b11, 2'b11, 2'b01,
        2'b10, 2'b00, 2'b10, 2'b11,
        2'b00, 2'b10, 2'b01, 2'b11
    };

endpackage

// File: rtl/circuit_test_sequencer_if.sv
// circuit_test_sequencer_if
// Bundles the run control, result and circuit-under-test signals of the
// sequencer. The master side is the test environment (it issues start and
// presents the evolved circuit's output); the slave side is the sequencer.
//   start          run request (single cycle)
//   dut_out        raw asynchronous output of the circuit under test
//   dut_in         stimulus to the circuit: [1] clock role, [0] data role
//   busy / done    run in progress / run finished
//   pass           done with no mismatches and no unstable vectors
//   mismatch_count, unstable_count, osc_count   saturating result counters
interface circuit_test_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             dut_out;
    logic [1:0]       dut_in;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] mismatch_count;
    logic [CNT_W-1:0] unstable_count;
    logic [CNT_W-1:0] osc_count;

    modport master (
        output start, dut_out,
        input  dut_in, busy, done, pass, mismatch_count, unstable_count, osc_count
    );

    modport slave (
        input  start, dut_out,
        output dut_in, busy, done, pass, mismatch_count, unstable_count, osc_count
    );
endinterface

// File: rtl/circuit_test_sequencer_sync_2ff.sv
// sync_2ff
// Two-flop synchronizer bringing the asynchronous circuit output into the
// clk domain. Both flops clear on reset.
//   clk, rst_n  clock and asynchronous active-low reset
//   d           asynchronous input
//   q           synchronized output (two cycles of latency)
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/circuit_test_sequencer.sv
// circuit_test_sequencer
// Applies the stimulus table to an evolved 2-input circuit, lets each vector
// settle, samples the synchronized output several times and compares it with
// a reference D flip-flop model, counting mismatching and unstable vectors.
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         circuit_test_sequencer_if.slave (start, dut_out in;
//               dut_in, busy, done, pass and result counters out)
// Optional feature: define TESTER_OSC_DETECT_EN to count output toggles seen
// during settle windows in osc_count; otherwise osc_count is tied to zero.
module circuit_test_sequencer
    import circuit_test_pkg::*;
#(
    parameter int NUM_VECTORS   = 16,
    parameter int SETTLE_CYCLES = 4,
    parameter int SAMPLES       = 3,
    parameter int CNT_W         = 8
) (
    input logic                      clk,
    input logic                      rst_n,
    circuit_test_sequencer_if.slave  bus
);
    // Window lengths below the supported minimum are raised to it
    localparam int SETTLE_N = (SETTLE_CYCLES < MIN_SETTLE_CYCLES) ? MIN_SETTLE_CYCLES : SETTLE_CYCLES;
    localparam int SAMPLE_N = (SAMPLES < MIN_SAMPLES) ? MIN_SAMPLES : SAMPLES;
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_N - 1);
    localparam logic [7:0] SAMPLE_LAST = 8'(SAMPLE_N - 1);
    localparam logic [3:0] LAST_VEC    = 4'(NUM_VECTORS - 1);

    state_t           state_q, state_d;
    logic [3:0]       vec_idx;
    logic [7:0]       step_cnt;
    logic [1:0]       dut_in_q;
    logic             model_q;
    logic             first_smp;
    logic             smp_equal;
    logic             dut_sync;
    logic             start_ok;
    logic [CNT_W-1:0] mism_q;
    logic [CNT_W-1:0] unst_q;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.dut_out),
        .q     (dut_sync)
    );

    // start only counts in IDLE or DONE; everywhere else it is ignored
    assign start_ok = bus.start && (state_q == ST_IDLE || state_q == ST_DONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (bus.start) state_d = ST_APPLY;
            ST_APPLY:         state_d = ST_SETTLE;
            ST_SETTLE:        if (step_cnt == SETTLE_LAST) state_d = ST_SAMPLE;
            ST_SAMPLE:        if (step_cnt == SAMPLE_LAST) state_d = ST_COMPARE;
            ST_COMPARE:       state_d = (vec_idx == LAST_VEC) ? ST_DONE : ST_APPLY;
            default:          state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // The model flop captures the data bit only on a 0->1 step of the clock
    // bit between the previously applied vector and the new one, so the
    // expected value for a vector is the model state after its APPLY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_idx   <= '0;
            step_cnt  <= '0;
            dut_in_q  <= 2'b00;
            model_q   <= 1'b0;
            first_smp <= 1'b0;
            smp_equal <= 1'b1;
            mism_q    <= '0;
            unst_q    <= '0;
        end else begin
            if (state_d == state_q && (state_q == ST_SETTLE || state_q == ST_SAMPLE))
                step_cnt <= step_cnt + 8'd1;
            else
                step_cnt <= '0;

            if (start_ok) begin
                vec_idx <= '0;
                model_q <= 1'b0;
                mism_q  <= '0;
                unst_q  <= '0;
            end

            case (state_q)
                ST_APPLY: begin
                    dut_in_q <= STIM_TABLE[vec_idx];
                    if (!dut_in_q[1] && STIM_TABLE[vec_idx][1])
                        model_q <= STIM_TABLE[vec_idx][0];
                end
                ST_SAMPLE: begin
                    if (step_cnt == 8'd0) begin
                        first_smp <= dut_sync;
                        smp_equal <= 1'b1;
                    end else if (dut_sync != first_smp) begin
                        smp_equal <= 1'b0;
                    end
                end
                ST_COMPARE: begin
                    if (!smp_equal) begin
                        if (unst_q != {CNT_W{1'b1}}) unst_q <= unst_q + 1'b1;
                    end else if (first_smp != model_q) begin
                        if (mism_q != {CNT_W{1'b1}}) mism_q <= mism_q + 1'b1;
                    end
                    if (vec_idx != LAST_VEC) vec_idx <= vec_idx + 4'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef TESTER_OSC_DETECT_EN
    logic [CNT_W-1:0] osc_q;
    logic             sync_prev;

    // Every change of the synchronized output inside a settle window counts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            osc_q     <= '0;
            sync_prev <= 1'b0;
        end else begin
            sync_prev <= dut_sync;
            if (start_ok)
                osc_q <= '0;
            else if (state_q == ST_SETTLE && dut_sync != sync_prev && osc_q != {CNT_W{1'b1}})
                osc_q <= osc_q + 1'b1;
        end
    end

    assign bus.osc_count = osc_q;
`else
    assign bus.osc_count = '0;
`endif

    assign bus.dut_in         = dut_in_q;
    assign bus.busy           = (state_q == ST_APPLY) || (state_q == ST_SETTLE) ||
                                (state_q == ST_SAMPLE) || (state_q == ST_COMPARE);
    assign bus.done           = (state_q == ST_DONE);
    assign bus.pass           = (state_q == ST_DONE) && (mism_q == '0) && (unst_q == '0);
    assign bus.mismatch_count = mism_q;
    assign bus.unstable_count = unst_q;
endmodule

// File: tb/tb_circuit_test_sequencer.sv
// tb_circuit_test_sequencer
// Drives two sequencers from one start: the main one (CNT_W=8) tests a
// behavioural circuit whose per-vector behaviour is picked at random
// (ideal D flip-flop, inverted, toggling, stuck-0, stuck-1); the second
// (CNT_W=2) always sees an output stuck at 1 so its mismatch counter
// saturates. Expected counts come from a vector-by-vector D flip-flop model.
module tb_circuit_test_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    circuit_test_sequencer_if #(.CNT_W(8)) ifc ();
    circuit_test_sequencer_if #(.CNT_W(2)) ifc2 ();

    circuit_test_sequencer #(
        .NUM_VECTORS(16), .SETTLE_CYCLES(4), .SAMPLES(3), .CNT_W(8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    circuit_test_sequencer #(
        .NUM_VECTORS(16), .SETTLE_CYCLES(4), .SAMPLES(3), .CNT_W(2)
    ) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc2.slave)
    );

    assign ifc2.start   = ifc.start;
    assign ifc2.dut_out = 1'b1;

    // Stimulus vectors {clock_role, data_role} in the order they are applied
    logic [1:0] ref_tab [16] = '{2'b11, 2'b01, 2'b10, 2'b00, 2'b11, 2'b10, 2'b00, 2'b10,
                                 2'b01, 2'b11, 2'b11, 2'b00, 2'b01, 2'b11, 2'b01, 2'b10};

    // Circuit behaviours: 0 ideal, 1 inverted, 2 toggling, 3 stuck-0, 4 stuck-1
    int   mode_tab [16];
    int   cur_mode = 0;
    logic ideal_q;
    logic ref_prev_clk = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_mis, exp_uns, exp_mis_sat;

    // Ideal D flip-flop clocked by the clock-role stimulus bit
    always @(posedge ifc.dut_in[1] or negedge rst_n) begin
        if (!rst_n) ideal_q <= 1'b0;
        else        ideal_q <= ifc.dut_in[0];
    end

    // Circuit under test, reacting half a cycle after each clock edge
    always @(negedge clk) begin
        case (cur_mode)
            0:       ifc.dut_out = ideal_q;
            1:       ifc.dut_out = ~ideal_q;
            2:       ifc.dut_out = ~ifc.dut_out;
            3:       ifc.dut_out = 1'b0;
            default: ifc.dut_out = 1'b1;
        endcase
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Predicts the result counters of one full run from the table and modes
    task automatic model_run();
        logic q, prev, outv;
        int mis2;
        q = 1'b0;
        prev = ref_prev_clk;
        exp_mis = 0;
        exp_uns = 0;
        mis2 = 0;
        for (int k = 0; k < 16; k++) begin
            if (!prev && ref_tab[k][1]) q = ref_tab[k][0];
            prev = ref_tab[k][1];
            if (q == 1'b0) mis2++;
            if (mode_tab[k] == 2) begin
                exp_uns++;
            end else begin
                case (mode_tab[k])
                    0:       outv = q;
                    1:       outv = ~q;
                    3:       outv = 1'b0;
                    default: outv = 1'b1;
                endcase
                if (outv != q) exp_mis++;
            end
        end
        exp_mis_sat = (mis2 > 3) ? 3 : mis2;
    endtask

    task automatic fill_modes(input int fixed);
        for (int k = 0; k < 16; k++)
            mode_tab[k] = (fixed < 0) ? int'($urandom_range(0, 4)) : fixed;
    endtask

    // One complete run; optionally pulses start once while busy
    task automatic apply_stimulus(input string name, input bit pulse_busy, input bit all_toggle);
        int pulse_k;
        model_run();
        pulse_k = $urandom_range(0, 15);
        @(negedge clk);
        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        check_output({name, "_busy_rise"}, ifc.busy, 1);
        check_output({name, "_done_drop"}, ifc.done, 0);
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            #1;
            cur_mode = mode_tab[k];
            if (pulse_busy && k == pulse_k) ifc.start = 1'b1;
            @(posedge clk);
            #1;
            ifc.start = 1'b0;
            repeat (6) @(posedge clk);
            #1;
            if (k == 15) begin
                check_output({name, "_done_early"}, ifc.done, 0);
                check_output({name, "_busy_late"}, ifc.busy, 1);
            end
            @(posedge clk);
            #1;
        end
        ref_prev_clk = ref_tab[15][1];
        check_output({name, "_done"}, ifc.done, 1);
        check_output({name, "_busy_end"}, ifc.busy, 0);
        check_output({name, "_mismatch"}, ifc.mismatch_count, exp_mis);
        check_output({name, "_unstable"}, ifc.unstable_count, exp_uns);
        check_output({name, "_pass"}, ifc.pass, (exp_mis == 0 && exp_uns == 0) ? 1 : 0);
        check_output({name, "_dut_in"}, ifc.dut_in, ref_tab[15]);
        check_output({name, "_sat_mismatch"}, ifc2.mismatch_count, exp_mis_sat);
        check_output({name, "_sat_unstable"}, ifc2.unstable_count, 0);
        check_output({name, "_sat_pass"}, ifc2.pass, 0);
`ifdef TESTER_OSC_DETECT_EN
        if (all_toggle) check_output({name, "_osc_seen"}, ifc.osc_count != 0, 1);
`else
        check_output({name, "_osc_zero"}, ifc.osc_count, 0);
        if (all_toggle) check_output({name, "_osc_off"}, ifc.osc_count, 0);
`endif
        cur_mode = 0;
    endtask

    task automatic check_cleared(input string name);
        check_output({name, "_busy"}, ifc.busy, 0);
        check_output({name, "_done"}, ifc.done, 0);
        check_output({name, "_pass"}, ifc.pass, 0);
        check_output({name, "_dut_in"}, ifc.dut_in, 0);
        check_output({name, "_mismatch"}, ifc.mismatch_count, 0);
        check_output({name, "_unstable"}, ifc.unstable_count, 0);
        check_output({name, "_osc"}, ifc.osc_count, 0);
        check_output({name, "_sat_busy"}, ifc2.busy, 0);
        check_output({name, "_sat_mismatch"}, ifc2.mismatch_count, 0);
    endtask

    initial begin
        ifc.start = 1'b0;
        ifc.dut_out = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_cleared("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_output("idle_busy", ifc.busy, 0);

        fill_modes(0);
        apply_stimulus("ideal", 1'b0, 1'b0);
        fill_modes(3);
        apply_stimulus("stuck0", 1'b0, 1'b0);
        fill_modes(2);
        apply_stimulus("toggle", 1'b0, 1'b1);
        fill_modes(0);
        apply_stimulus("ideal_pulse", 1'b1, 1'b0);
        for (int r = 0; r < 4; r++) begin
            fill_modes(-1);
            apply_stimulus($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), 1'b0);
        end

        // Abandon a run partway through and start a fresh one
        fill_modes(-1);
        @(negedge clk);
        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        for (int c = 0; c < 49; c++) begin
            @(posedge clk);
            #1;
            cur_mode = mode_tab[c / 9];
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_cleared("midrun_reset");
        ref_prev_clk = 1'b0;
        cur_mode = 0;
        @(negedge clk);
        rst_n = 1'b1;
        fill_modes(0);
        apply_stimulus("after_reset", 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/circuit_test_sequencer.md
CIRCUIT_TEST_SEQUENCER -- requirements
Module: circuit_test_sequencer

Interface
REQ-001 SHALL have parameter NUM_VECTORS, default 16, meaning the number of stimulus vectors applied per run (1..16).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 4, meaning the wait after each vector change before sampling (minimum 2).
REQ-003 SHALL have parameter SAMPLES, default 3, meaning the number of consecutive samples of the evolved-circuit output per vector (minimum 1).
REQ-004 SHALL have parameter CNT_W, default 8, meaning the width of the result counters.
REQ-005 SHALL have port clk, input, 1, the single clock.
REQ-006 SHALL have port rst_n, input, 1, the reset: asynchronous, active-low.
REQ-007 SHALL have port start, input, 1, a single-cycle run request.
REQ-008 SHALL have port dut_out, input, 1, the asynchronous output of the evolved 2-input circuit under test.
REQ-009 SHALL have port dut_in, output, 2, the stimulus to the circuit under test: [1] is the clock-role input and [0] is the data-role input.
REQ-010 SHALL have port busy, output, 1, high while a run is in progress.
REQ-011 SHALL have port done, output, 1, high from run completion until the next accepted start.
REQ-012 SHALL have port mismatch_count, output, CNT_W, the number of stable vectors whose value differed from the expected value.
REQ-013 SHALL have port unstable_count, output, CNT_W, the number of vectors whose samples disagreed.
REQ-014 SHALL have port osc_count, output, CNT_W, the number of output toggles seen during settle windows.
REQ-015 SHALL have port pass, output, 1, meaning done with both mismatch_count and unstable_count equal to 0.

Function
REQ-016 SHALL pass dut_out through a 2-flop synchronizer before any use.
REQ-017 SHALL implement the state machine IDLE -> APPLY -> SETTLE -> SAMPLE -> COMPARE, with COMPARE going to APPLY for the next vector, or to DONE after vector NUM_VECTORS-1.
REQ-018 SHALL leave IDLE or DONE on start=1 and ignore start in every other state.
REQ-019 SHALL, on an accepted start, clear all counters, the vector index and the model state in the same cycle.
REQ-020 SHALL, in APPLY (1 cycle), drive dut_in from the stimulus table entry at the vector index; dut_in holds until the next APPLY, and the table is in vector order.
REQ-021 SHALL spend exactly SETTLE_CYCLES cycles in SETTLE and SAMPLES cycles in SAMPLE, then 1 cycle in COMPARE, so each vector takes 2+SETTLE_CYCLES+SAMPLES cycles.
REQ-022 SHALL keep a reference D flip-flop model: q updates to dut_in[0] only when dut_in[1] goes 0->1 between consecutive vectors; q resets to 0; expected = q after the update.
REQ-023 SHALL, in COMPARE, increment unstable_count if the samples are not all equal, otherwise increment mismatch_count if the sample differs from expected; the two are mutually exclusive per vector.
REQ-024 SHALL saturate all counters at 2^CNT_W-1 and never wrap.
REQ-025 SHALL hold busy=1 in APPLY through COMPARE, and assert done on entry to DONE.
REQ-026 SHALL, when start is accepted in DONE, drop done and raise busy on the next edge.

Reset
REQ-027 SHALL, on rst_n low, immediately (asynchronously) place the FSM in IDLE, set dut_in=2'b00, busy=0, done=0, pass=0, clear all counters and the synchronizer, and set model q=0.
REQ-028 SHALL abandon a run in progress when rst_n is asserted mid-run and leave no partial results.

Configuration
REQ-029 SHALL, with TESTER_OSC_DETECT_EN defined, count every change of the synchronized output during SETTLE into osc_count (saturating).
REQ-030 SHALL, without TESTER_OSC_DETECT_EN, tie osc_count to 0 and omit its logic; all other behaviour is identical.

Structure
REQ-031 SHALL place the state enum, the 16-entry 2-bit stimulus table, and the minimum values for SETTLE_CYCLES and SAMPLES in package circuit_test_pkg.
REQ-032 SHALL implement the synchronizer as sub-module sync_2ff.

Verification
REQ-033 SHALL verify: an ideal D flip-flop model as DUT, start -> done after 16*(2+4+3)=144 cycles (plus synchronizer latency), mismatch_count=0, unstable_count=0, pass=1.
REQ-034 SHALL verify: DUT output stuck at 0 -> mismatch_count equals the number of table entries whose expected value is 1, and pass=0.
REQ-035 SHALL verify: DUT output toggling every cycle -> unstable_count=16, mismatch_count=0, and osc_count>0 only with the macro defined.
REQ-036 SHALL verify: start pulsed while busy -> ignored, and results are identical to an uninterrupted run.
REQ-037 SHALL verify: rst_n asserted at cycle 50 of a run -> all outputs 0 immediately, and a new start runs cleanly.
REQ-038 SHALL verify: CNT_W=2 with DUT output stuck at 1 -> mismatch_count saturates at 3.
